rd_burst_sched: RTL and testbench
=================================

Name: rd_burst_sched

Overview:
Read-side scheduler for the async FIFO. It shares the FIFO read port between two consumers that request bursts of words. It arbitrates round-robin, sequences read_enable without underflowing the FIFO, and routes each returned word to the granted consumer with a tag. It also owns the aempty_value configuration that drives the FIFO read interface.

Parameters:
DATA_W, 32, read_data / out_data width
LEN_W, 6, burst length width; legal lengths 0..32
LVL_W, 6, rd_level width
AE_W, 5, aempty_value width

Ports:
rclk  in  1  read-domain clock; all logic on rising edge
hw_rst  in  1  asynchronous active-high reset
req  in  2  per-consumer burst request, level; held until done
req_len0  in  LEN_W  burst length, consumer 0; sampled at grant
req_len1  in  LEN_W  burst length, consumer 1; sampled at grant
cfg_aempty  in  AE_W  almost-empty threshold to program
gnt  out  2  one-hot grant, held for the whole burst
out_valid  out  1  out_data valid this cycle
out_data  out  DATA_W  word returned from FIFO
out_id  out  1  consumer index owning out_data
done  out  2  one-cycle pulse per consumer at burst end
read_enable  out  1  FIFO read strobe
aempty_value  out  AE_W  registered copy of cfg_aempty
read_data  in  DATA_W  FIFO read data, valid 1 cycle after read_enable
rdempty  in  1  FIFO empty
rd_level  in  LVL_W  FIFO occupancy, read domain
underflow  in  1  FIFO underflow indication
underflow_err  out  1  sticky: underflow seen while this block read

Behaviour:
- Reset (async, hw_rst=1): all outputs 0. State IDLE. Remaining count 0. RR pointer favours consumer 0. Mid-burst reset abandons the burst with no done pulse.
- aempty_value <= cfg_aempty every cycle. Takes effect 1 cycle after a change.
- FSM states: IDLE, BURST, FLUSH, DONE.
- IDLE:
  - If any req bit is set, grant one consumer.
  - If both are set, grant the consumer not served last. The first contention after reset goes to 0.
  - On grant: gnt set next cycle; remaining <= captured req_len.
  - -> BURST, or -> DONE if the captured length is 0.
- BURST:
  - read_enable = remaining!=0 && !rdempty && (rd_level>=2 || !read_enable_q).
  - This never issues a second read against a single word already being read.
  - Each read_enable decrements remaining.
  - When remaining reaches 0 after a read -> FLUSH.
  - rdempty stalls the burst indefinitely, with no timeout.
- FLUSH: waits 1 cycle for the last word, then -> DONE.
- Return path:
  - out_valid = read_enable delayed 1 cycle.
  - out_data = read_data, out_id = granted index, both in the same cycle as out_valid.
  - Exactly req_len words are returned per burst, in FIFO order.
- DONE:
  - done[id] pulses 1 cycle; gnt drops in the same cycle; RR pointer updates.
  - Return to IDLE.
  - A req still high in the cycle after DONE is treated as a new request.
- Minimum gap between bursts: 1 idle cycle (the IDLE grant cycle).
- Throughput: 1 word/cycle while rd_level>=2. It alternates read / no-read when rd_level is 1.
- underflow_err sets if underflow=1 in the cycle after read_enable. It stays set until reset and does not halt the FSM.
- A req deasserted mid-burst is ignored; the burst completes.

Test Plan:
- Reset, FIFO holds 8 words, req=01, len0=4 -> gnt=01; 4 consecutive read_enable; out_valid×4 with out_id=0 in FIFO order; done=01 one cycle after the last data; gnt=00.
- req=11 held, both len=2, FIFO deep -> grant order 0,1,0,1. Each done pulse is followed by the other consumer's gnt after 1 idle cycle.
- rd_level=1, len0=3, writes trickle one word every 5 cycles -> read_enable never asserts on consecutive cycles at level 1; no underflow; underflow_err=0; 3 words delivered.
- len1=0, req=10 -> gnt=10; no read_enable; done=10 within 3 cycles.
- hw_rst asserted mid-burst after 2 of 6 reads -> outputs 0 immediately; no done pulse; after release, a new req=01 len=1 completes normally.
- cfg_aempty=7 -> aempty_value=7 next cycle. Force underflow=1 after a read -> underflow_err=1 and stays 1 until hw_rst.

Source files
------------

// File: rtl/rd_burst_sched.sv
// rd_burst_sched: read-side burst scheduler for an async FIFO.
// Two consumers request bursts. They are granted round-robin, and the FIFO
// read port is driven without underflowing it. Each returned word goes back
// tagged with the owning consumer's index.
//
// Ports:
//   rclk, hw_rst        read clock, asynchronous active-high reset
//   req[1:0]            level burst requests, held until done
//   req_len0/1          burst lengths, sampled at grant (0..32)
//   cfg_aempty          almost-empty threshold, registered to aempty_value
//   gnt[1:0]            one-hot grant, held for the whole burst
//   out_valid/data/id   returned word, valid one cycle after read_enable
//   done[1:0]           one-cycle end-of-burst pulse per consumer
//   read_enable         FIFO read strobe
//   read_data           FIFO read data (valid 1 cycle after read_enable)
//   rdempty, rd_level   FIFO status, read domain
//   underflow           FIFO underflow flag
//   underflow_err       sticky: underflow seen in the cycle after a read
module rd_burst_sched #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 6,
  parameter int LVL_W  = 6,
  parameter int AE_W   = 5
) (
  input  logic              rclk,
  input  logic              hw_rst,
  input  logic [1:0]        req,
  input  logic [LEN_W-1:0]  req_len0,
  input  logic [LEN_W-1:0]  req_len1,
  input  logic [AE_W-1:0]   cfg_aempty,
  output logic [1:0]        gnt,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_id,
  output logic [1:0]        done,
  output logic              read_enable,
  output logic [AE_W-1:0]   aempty_value,
  input  logic [DATA_W-1:0] read_data,
  input  logic              rdempty,
  input  logic [LVL_W-1:0]  rd_level,
  input  logic              underflow,
  output logic              underflow_err
);

  typedef enum logic [1:0] {IDLE, BURST, FLUSH, DONE} state_t;

  state_t           r_state;
  logic [LEN_W-1:0] r_remaining;
  logic [1:0]       r_gnt;
  logic [1:0]       r_done;
  logic             r_id;
  logic             r_last;      // consumer served last; reset value favours consumer 0
  logic             r_re_q;      // read_enable delayed one cycle
  logic             r_uf_err;
  logic [AE_W-1:0]  r_aempty;

  logic             w_pick;
  logic [LEN_W-1:0] w_len;
  logic             w_rd;

  always_comb begin
    w_pick = 1'b0;
    w_len  = '0;
    w_rd   = 1'b0;
    w_pick = (req == 2'b11) ? ~r_last : req[1];
    w_len  = w_pick ? req_len1 : req_len0;
    // A level of 1 may already be covered by last cycle's read, so in that
    // case only read when no read was issued in the previous cycle.
    w_rd   = (r_state == BURST) && (r_remaining != '0) && !rdempty &&
             ((rd_level >= LVL_W'(2)) || !r_re_q);
  end

  always_ff @(posedge rclk or posedge hw_rst) begin
    if (hw_rst) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_gnt       <= '0;
      r_done      <= '0;
      r_id        <= 1'b0;
      r_last      <= 1'b1;
      r_re_q      <= 1'b0;
      r_uf_err    <= 1'b0;
      r_aempty    <= '0;
    end else begin
      r_aempty <= cfg_aempty;
      r_re_q   <= w_rd;
      r_done   <= '0;
      if (r_re_q && underflow)
        r_uf_err <= 1'b1;
      case (r_state)
        IDLE: begin
          if (req != 2'b00) begin
            r_id        <= w_pick;
            r_gnt       <= w_pick ? 2'b10 : 2'b01;
            r_remaining <= w_len;
            // A zero-length burst takes the flush slot so its grant is
            // visible for one cycle before the done pulse.
            r_state     <= (w_len == '0) ? FLUSH : BURST;
          end
        end
        BURST: begin
          if (w_rd) begin
            r_remaining <= r_remaining - LEN_W'(1);
            if (r_remaining == LEN_W'(1))
              r_state <= FLUSH;
          end
        end
        FLUSH: begin
          r_done  <= r_gnt;
          r_gnt   <= '0;
          r_last  <= r_id;
          r_state <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt           = r_gnt;
  assign done          = r_done;
  assign out_valid     = r_re_q;
  assign out_data      = r_re_q ? read_data : '0;
  assign out_id        = r_id;
  assign read_enable   = w_rd;
  assign aempty_value  = r_aempty;
  assign underflow_err = r_uf_err;

endmodule

// File: tb/tb_rd_burst_sched.sv
module tb_rd_burst_sched;

  logic        rclk = 1'b0;
  logic        hw_rst = 1'b1;
  logic [1:0]  req = '0;
  logic [5:0]  req_len0 = '0, req_len1 = '0;
  logic [4:0]  cfg_aempty = '0;
  logic [1:0]  gnt, done;
  logic        out_valid, out_id, read_enable, underflow_err, rdempty, underflow;
  logic [31:0] out_data, read_data;
  logic [4:0]  aempty_value;
  logic [5:0]  rd_level;

  int checks = 0, errors = 0;
  int cyc = 0;

  // FIFO model: occupancy seen by the DUT lags one cycle, as in an async FIFO
  logic [31:0] q[$];
  logic [5:0]  r_lvl = '0;
  logic        uf_q = 1'b0, force_uf = 1'b0;
  logic [31:0] rd_q = '0;
  int          wseq = 0, exp_base = 0;

  assign rd_level  = r_lvl;
  assign rdempty   = (r_lvl == 6'd0);
  assign read_data = rd_q;
  assign underflow = uf_q | force_uf;

  rd_burst_sched #(.DATA_W(32), .LEN_W(6), .LVL_W(6), .AE_W(5)) dut (
    .rclk(rclk), .hw_rst(hw_rst), .req(req), .req_len0(req_len0), .req_len1(req_len1),
    .cfg_aempty(cfg_aempty), .gnt(gnt), .out_valid(out_valid), .out_data(out_data),
    .out_id(out_id), .done(done), .read_enable(read_enable), .aempty_value(aempty_value),
    .read_data(read_data), .rdempty(rdempty), .rd_level(rd_level), .underflow(underflow),
    .underflow_err(underflow_err)
  );

  always #5 rclk = ~rclk;

  always @(posedge rclk) begin
    cyc++;
    r_lvl <= 6'(q.size());
    uf_q  <= 1'b0;
    if (read_enable) begin
      if (q.size() > 0) rd_q <= q.pop_front();
      else begin rd_q <= 32'hBAD0BAD0; uf_q <= 1'b1; end
    end
  end

  // Return-path monitor
  logic [31:0] got_d[$];
  logic        got_id[$];
  int          consec = 0, lvl1_reads = 0, done_cnt = 0;
  logic        re_prev = 1'b0;

  always @(negedge rclk) begin
    if (out_valid) begin got_d.push_back(out_data); got_id.push_back(out_id); end
    if (read_enable && rd_level == 6'd1) lvl1_reads++;
    if (read_enable && re_prev && rd_level == 6'd1) consec++;
    if (done != 2'b00) done_cnt++;
    re_prev = read_enable;
  end

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      q.push_back(32'hC0DE_0000 + 32'(wseq));
      wseq++;
    end
  endtask

  task automatic fifo_clear;
    q.delete();
    exp_base = wseq;
    repeat (2) @(negedge rclk);
  endtask

  task automatic wait_done(input int maxc, output logic [1:0] d, output bit ok);
    d = '0; ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge rclk);
      if (done != 2'b00) begin d = done; ok = 1'b1; end
    end
  endtask

  task automatic test_reset;
    @(negedge rclk);
    checks++; if ({gnt, done, out_valid, out_id, read_enable, underflow_err} !== 8'd0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0", {gnt, done, out_valid, out_id, read_enable, underflow_err}); end
    checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset_data got %h exp 0", out_data); end
    checks++; if (aempty_value !== 5'd0) begin errors++; $display("FAIL reset_aempty got %0d exp 0", aempty_value); end
    hw_rst = 1'b0;
  endtask

  task automatic test_rr;
    logic [1:0] gev[$];
    int gcyc[$], dcyc[$];
    logic [1:0] pg;
    logic [31:0] ed;
    fifo_clear; push(12); repeat (2) @(negedge rclk);
    got_d.delete(); got_id.delete();
    req_len0 = 6'd2; req_len1 = 6'd2; req = 2'b11; pg = '0;
    for (int i = 0; i < 60 && dcyc.size() < 4; i++) begin
      @(negedge rclk);
      if (gnt != 2'b00 && pg == 2'b00) begin gev.push_back(gnt); gcyc.push_back(cyc); end
      if (done != 2'b00) begin dcyc.push_back(cyc); if (dcyc.size() == 4) req = 2'b00; end
      pg = gnt;
    end
    checks++; if (dcyc.size() !== 4) begin errors++; $display("FAIL rr_timeout got %0d dones exp 4", dcyc.size()); end
    for (int k = 0; k < 4 && k < gev.size(); k++) begin
      checks++; if (gev[k] !== ((k % 2) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL rr_order[%0d] got %b exp %b", k, gev[k], ((k % 2) ? 2'b10 : 2'b01)); end
    end
    for (int k = 0; k < 3 && k + 1 < gcyc.size() && k < dcyc.size(); k++) begin
      checks++; if (gcyc[k+1] - dcyc[k] !== 2) begin
        errors++; $display("FAIL rr_gap[%0d] got %0d exp 2", k, gcyc[k+1] - dcyc[k]); end
    end
    repeat (2) @(negedge rclk);
    checks++; if (got_d.size() !== 8) begin errors++; $display("FAIL rr_count got %0d exp 8", got_d.size()); end
    for (int k = 0; k < 8 && k < got_d.size(); k++) begin
      ed = 32'hC0DE_0000 + 32'(exp_base + k);
      checks++; if (got_d[k] !== ed || got_id[k] !== 1'((k / 2) % 2)) begin
        errors++; $display("FAIL rr_word[%0d] got %h/%0d exp %h/%0d", k, got_d[k], got_id[k], ed, (k / 2) % 2); end
    end
  endtask

  task automatic test_single;
    logic [3:0] pat;
    logic [31:0] ed;
    fifo_clear; push(8); repeat (2) @(negedge rclk);
    got_d.delete(); got_id.delete();
    req_len0 = 6'd4; req = 2'b01; pat = '0;
    @(negedge rclk);
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL single_gnt got %b exp 01", gnt); end
    pat = {pat[2:0], read_enable};
    for (int i = 0; i < 3; i++) begin @(negedge rclk); pat = {pat[2:0], read_enable}; end
    checks++; if (pat !== 4'b1111) begin errors++; $display("FAIL single_re_pattern got %b exp 1111", pat); end
    @(negedge rclk);
    checks++; if ({read_enable, out_valid} !== 2'b01) begin
      errors++; $display("FAIL single_flush got re/ov %b exp 01", {read_enable, out_valid}); end
    @(negedge rclk);
    checks++; if ({done, gnt} !== 4'b0100) begin errors++; $display("FAIL single_done got done/gnt %b exp 0100", {done, gnt}); end
    req = 2'b00;
    @(negedge rclk);
    checks++; if (done !== 2'b00) begin errors++; $display("FAIL single_done_pulse got %b exp 00", done); end
    @(negedge rclk);
    checks++; if (got_d.size() !== 4) begin errors++; $display("FAIL single_count got %0d exp 4", got_d.size()); end
    for (int k = 0; k < 4 && k < got_d.size(); k++) begin
      ed = 32'hC0DE_0000 + 32'(exp_base + k);
      checks++; if (got_d[k] !== ed || got_id[k] !== 1'b0) begin
        errors++; $display("FAIL single_word[%0d] got %h/%0d exp %h/0", k, got_d[k], got_id[k], ed); end
    end
  endtask

  task automatic test_trickle;
    int pushed;
    logic [1:0] d;
    logic [31:0] ed;
    fifo_clear;
    got_d.delete(); got_id.delete(); consec = 0; lvl1_reads = 0;
    req_len0 = 6'd3; req = 2'b01; pushed = 0; d = '0;
    for (int i = 0; i < 60 && d == 2'b00; i++) begin
      @(negedge rclk);
      if (i % 5 == 0 && pushed < 3) begin push(1); pushed++; end
      if (done != 2'b00) d = done;
    end
    req = 2'b00;
    checks++; if (d !== 2'b01) begin errors++; $display("FAIL trickle_done got %b exp 01", d); end
    repeat (2) @(negedge rclk);
    checks++; if (consec !== 0) begin errors++; $display("FAIL trickle_consec got %0d exp 0", consec); end
    checks++; if (lvl1_reads !== 3) begin errors++; $display("FAIL trickle_lvl1_reads got %0d exp 3", lvl1_reads); end
    checks++; if (underflow_err !== 1'b0) begin errors++; $display("FAIL trickle_uferr got %b exp 0", underflow_err); end
    checks++; if (got_d.size() !== 3) begin errors++; $display("FAIL trickle_count got %0d exp 3", got_d.size()); end
    for (int k = 0; k < 3 && k < got_d.size(); k++) begin
      ed = 32'hC0DE_0000 + 32'(exp_base + k);
      checks++; if (got_d[k] !== ed) begin errors++; $display("FAIL trickle_word[%0d] got %h exp %h", k, got_d[k], ed); end
    end
  endtask

  task automatic test_zero_len;
    int res;
    res = 0;
    req_len1 = 6'd0; req = 2'b10;
    @(negedge rclk);
    checks++; if ({gnt, read_enable} !== 3'b100) begin errors++; $display("FAIL zero_gnt got gnt/re %b exp 100", {gnt, read_enable}); end
    if (read_enable) res++;
    @(negedge rclk);
    checks++; if ({done, gnt} !== 4'b1000) begin errors++; $display("FAIL zero_done got done/gnt %b exp 1000", {done, gnt}); end
    if (read_enable) res++;
    req = 2'b00;
    checks++; if (res !== 0) begin errors++; $display("FAIL zero_reads got %0d exp 0", res); end
    repeat (2) @(negedge rclk);
  endtask

  task automatic test_reset_mid;
    int n, dc;
    logic [1:0] d;
    bit ok;
    fifo_clear; push(8); repeat (2) @(negedge rclk);
    req_len0 = 6'd6; req = 2'b01; n = 0;
    for (int i = 0; i < 20 && n < 2; i++) begin
      @(negedge rclk);
      if (read_enable) n++;
    end
    checks++; if (n !== 2) begin errors++; $display("FAIL midrst_reads got %0d exp 2", n); end
    @(posedge rclk); #2;
    hw_rst = 1'b1; req = 2'b00; dc = done_cnt;
    #1;
    checks++; if ({gnt, done, out_valid, read_enable, out_id} !== 7'd0) begin
      errors++; $display("FAIL midrst_outputs got %b exp 0", {gnt, done, out_valid, read_enable, out_id}); end
    checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL midrst_data got %h exp 0", out_data); end
    repeat (3) @(negedge rclk);
    hw_rst = 1'b0;
    fifo_clear; push(2); repeat (2) @(negedge rclk);
    checks++; if (done_cnt !== dc) begin errors++; $display("FAIL midrst_no_done got %0d exp %0d", done_cnt, dc); end
    got_d.delete(); got_id.delete();
    req_len0 = 6'd1; req = 2'b01;
    wait_done(20, d, ok);
    req = 2'b00;
    checks++; if (!ok || d !== 2'b01) begin errors++; $display("FAIL midrst_after got done %b ok %0d exp 01 1", d, ok); end
    repeat (2) @(negedge rclk);
    checks++; if (got_d.size() !== 1 || got_d[0] !== 32'hC0DE_0000 + 32'(exp_base) || got_id[0] !== 1'b0) begin
      errors++; $display("FAIL midrst_word got n=%0d %h exp n=1 %h", got_d.size(),
                         (got_d.size() > 0) ? got_d[0] : 32'd0, 32'hC0DE_0000 + 32'(exp_base)); end
  endtask

  task automatic test_cfg_underflow;
    logic [1:0] d;
    bit ok;
    int n;
    cfg_aempty = 5'd7;
    #1;
    checks++; if (aempty_value !== 5'd0) begin errors++; $display("FAIL aempty_early got %0d exp 0", aempty_value); end
    @(negedge rclk);
    checks++; if (aempty_value !== 5'd7) begin errors++; $display("FAIL aempty_value got %0d exp 7", aempty_value); end
    force_uf = 1'b1;
    @(negedge rclk);
    force_uf = 1'b0;
    @(negedge rclk);
    checks++; if (underflow_err !== 1'b0) begin errors++; $display("FAIL uf_no_read got %b exp 0", underflow_err); end
    fifo_clear; push(2); repeat (2) @(negedge rclk);
    req_len1 = 6'd1; req = 2'b10; n = 0;
    for (int i = 0; i < 10 && n == 0; i++) begin
      @(negedge rclk);
      if (read_enable) n = 1;
    end
    checks++; if (n !== 1) begin errors++; $display("FAIL uf_read_seen got %0d exp 1", n); end
    @(negedge rclk);
    force_uf = 1'b1;
    @(negedge rclk);
    force_uf = 1'b0;
    checks++; if (underflow_err !== 1'b1) begin errors++; $display("FAIL uf_set got %b exp 1", underflow_err); end
    wait_done(10, d, ok);
    req = 2'b00;
    repeat (3) @(negedge rclk);
    checks++; if (underflow_err !== 1'b1) begin errors++; $display("FAIL uf_sticky got %b exp 1", underflow_err); end
    hw_rst = 1'b1;
    #1;
    checks++; if (underflow_err !== 1'b0) begin errors++; $display("FAIL uf_reset got %b exp 0", underflow_err); end
    @(negedge rclk);
    hw_rst = 1'b0;
  endtask

  initial begin
    test_reset;
    test_rr;
    test_single;
    test_trickle;
    test_zero_len;
    test_reset_mid;
    test_cfg_underflow;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
